dmem_responder: RTL and testbench

- Data-memory responder for the pipelined MIPS core's data port, sitting on the memory-stage request interface.
- Accepts one word-aligned load or store at a time from the memory stage (address = ALU result, write data = forwarded rt value).
- Serves it from an internal word array after a programmable latency.
- Raises a stall request to the hazard unit until the response is ready.

---
 rtl/dmem_responder.sv | 125 ++++++++++++
 tb/tb_dmem_responder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: serves one load/store at a time after LATENCY cycles.
// Define DMEM_ADDR_CHECK_EN to flag (and suppress) misaligned word accesses via addr_err.
module dmem_responder #(
  parameter int AW      = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_en,
  input  logic [3:0]  req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] rdata,
  output logic        data_ok,
  output logic        stall,
  output logic        addr_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam bit         DIRECT   = (LATENCY == 1);
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_cnt;
  logic [3:0]      r_wen;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_wdata;
  logic            r_mis;
  logic [31:0]     r_rdata;
  logic            r_data_ok;
  logic            r_addr_err;
  logic [31:0]     r_mem [0:(1<<AW)-1];

  logic            w_accept;
  logic            w_finish;
  logic            w_mis_in;
  logic [3:0]      w_wen;
  logic [AW-1:0]   w_idx;
  logic [31:0]     w_wdata;
  logic            w_mis;
  logic            w_unused;

`ifdef DMEM_ADDR_CHECK_EN
  assign w_mis_in = (req_addr[1:0] != 2'b00) &&
                    ((req_wen == 4'b0000) || (req_wen == 4'b1111));
`else
  assign w_mis_in = 1'b0;
`endif

  assign w_unused = ^{req_addr[31:AW+2], req_addr[1:0]};

  // With LATENCY=1 the access completes on its acceptance edge, so it uses the live inputs.
  assign w_accept = (r_state == IDLE) && req_en;
  assign w_finish = DIRECT ? w_accept : ((r_state == BUSY) && (r_cnt == 4'd0));
  assign w_wen    = DIRECT ? req_wen : r_wen;
  assign w_idx    = DIRECT ? req_addr[AW+1:2] : r_idx;
  assign w_wdata  = DIRECT ? req_wdata : r_wdata;
  assign w_mis    = DIRECT ? w_mis_in : r_mis;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (req_en) begin
          if (DIRECT) w_next = DONE;
          else        w_next = BUSY;
        end
      end
      BUSY:    if (r_cnt == 4'd0) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    rdata    = r_rdata;
    data_ok  = r_data_ok;
    addr_err = r_addr_err;
    stall    = req_en & ~r_data_ok;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt      <= 4'd0;
      r_wen      <= 4'd0;
      r_idx      <= '0;
      r_wdata    <= 32'd0;
      r_mis      <= 1'b0;
      r_rdata    <= 32'd0;
      r_data_ok  <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_data_ok  <= w_finish;
      r_addr_err <= w_finish & w_mis;
      if (w_accept) begin
        r_wen   <= req_wen;
        r_idx   <= req_addr[AW+1:2];
        r_wdata <= req_wdata;
        r_mis   <= w_mis_in;
        r_cnt   <= CNT_INIT;
      end else if (r_state == BUSY) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_finish && (w_wen == 4'b0000) && !w_mis)
        r_rdata <= r_mem[w_idx];
    end
  end

  // The array has no reset; a store completing on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (!rst && w_finish && (w_wen != 4'b0000) && !w_mis) begin
      for (int i = 0; i < 4; i++) begin
        if (w_wen[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: three instances (LATENCY 1, 2, 4) against a word-array model.
// Honors DMEM_ADDR_CHECK_EN when the design is built with it.
module tb_dmem_responder;

`ifdef DMEM_ADDR_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  localparam int LATS[3] = '{1, 2, 4};

  logic        clk = 1'b0;
  logic        rst;
  logic        reqEn[3];
  logic [3:0]  reqWen[3];
  logic [31:0] reqAddr[3];
  logic [31:0] reqWdata[3];
  logic [31:0] rdataV[3];
  logic        dataOk[3];
  logic        stallV[3];
  logic        addrErr[3];

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model[3][1024];
  logic [31:0] lastRdata[3];

  always #5 clk = ~clk;

  dmem_responder #(.AW(10), .LATENCY(1)) dut0 (
    .clk(clk), .rst(rst), .req_en(reqEn[0]), .req_wen(reqWen[0]), .req_addr(reqAddr[0]),
    .req_wdata(reqWdata[0]), .rdata(rdataV[0]), .data_ok(dataOk[0]), .stall(stallV[0]),
    .addr_err(addrErr[0]));

  dmem_responder #(.AW(10), .LATENCY(2)) dut1 (
    .clk(clk), .rst(rst), .req_en(reqEn[1]), .req_wen(reqWen[1]), .req_addr(reqAddr[1]),
    .req_wdata(reqWdata[1]), .rdata(rdataV[1]), .data_ok(dataOk[1]), .stall(stallV[1]),
    .addr_err(addrErr[1]));

  dmem_responder #(.AW(10), .LATENCY(4)) dut2 (
    .clk(clk), .rst(rst), .req_en(reqEn[2]), .req_wen(reqWen[2]), .req_addr(reqAddr[2]),
    .req_wdata(reqWdata[2]), .rdata(rdataV[2]), .data_ok(dataOk[2]), .stall(stallV[2]),
    .addr_err(addrErr[2]));

  function automatic logic misaligned(input logic [31:0] a, input logic [3:0] wen);
    return CHECK_EN && (a[1:0] != 2'b00) && ((wen == 4'h0) || (wen == 4'hF));
  endfunction

  task automatic checkOutput(input string tag, input int k, input logic [31:0] obs,
                             input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s[%0d] observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic checkQuiet(input int k);
    checkOutput("idle_rdata", k, rdataV[k], lastRdata[k]);
    checkOutput("idle_ok", k, 32'(dataOk[k]), 32'd0);
    checkOutput("idle_stall", k, 32'(stallV[k]), 32'd0);
    checkOutput("idle_err", k, 32'(addrErr[k]), 32'd0);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) reqEn[k] = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) checkQuiet(k);
    end
  endtask

  // One full handshake; returns at the falling edge inside the DONE cycle, request still held.
  task automatic applyStimulus(input int k, input logic [3:0] wen, input logic [31:0] addr,
                               input logic [31:0] wdata);
    int          w;
    logic        mis;
    logic [31:0] expR;
    w    = int'(addr[11:2]);
    mis  = misaligned(addr, wen);
    expR = lastRdata[k];
    if (!mis) begin
      if (wen == 4'h0) expR = model[k][w];
      else for (int i = 0; i < 4; i++)
        if (wen[i]) model[k][w][8*i +: 8] = wdata[8*i +: 8];
    end
    lastRdata[k] = expR;
    @(negedge clk);
    reqEn[k] = 1'b1; reqWen[k] = wen; reqAddr[k] = addr; reqWdata[k] = wdata;
    #1;
    checkOutput("req_stall", k, 32'(stallV[k]), 32'd1);
    checkOutput("req_ok", k, 32'(dataOk[k]), 32'd0);
    for (int c = 1; c < LATS[k]; c++) begin
      @(negedge clk);
      checkOutput("busy_stall", k, 32'(stallV[k]), 32'd1);
      checkOutput("busy_ok", k, 32'(dataOk[k]), 32'd0);
    end
    @(negedge clk);
    checkOutput("done_ok", k, 32'(dataOk[k]), 32'd1);
    checkOutput("done_stall", k, 32'(stallV[k]), 32'd0);
    checkOutput("done_rdata", k, rdataV[k], expR);
    checkOutput("done_err", k, 32'(addrErr[k]), 32'(mis));
  endtask

  initial begin
    logic [31:0] r;
    logic [9:0]  word;
    logic [3:0]  wen;
    logic [1:0]  low;

    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      reqEn[k] = 1'b0; reqWen[k] = 4'h0; reqAddr[k] = 32'd0; reqWdata[k] = 32'd0;
      lastRdata[k] = 32'd0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idleCycles(5);

    applyStimulus(1, 4'hF, 32'h10, 32'hDEADBEEF);
    idleCycles(1);
    applyStimulus(1, 4'h0, 32'h10, 32'h0);
    checkOutput("deadbeef", 1, rdataV[1], 32'hDEADBEEF);
    idleCycles(1);

    applyStimulus(1, 4'hF, 32'h20, 32'h11223344);
    applyStimulus(1, 4'b0010, 32'h20, 32'h0000AA00);
    applyStimulus(1, 4'h0, 32'h20, 32'h0);
    checkOutput("merge", 1, rdataV[1], 32'h1122AA44);
    idleCycles(1);

    applyStimulus(0, 4'hF, 32'h0, 32'hA5A50001);
    applyStimulus(0, 4'hF, 32'h4, 32'h5A5A0002);
    applyStimulus(0, 4'h0, 32'h0, 32'h0);
    applyStimulus(0, 4'h0, 32'h4, 32'h0);
    checkOutput("b2b_load", 0, rdataV[0], 32'h5A5A0002);
    idleCycles(1);

    // Store aborted by reset while BUSY must leave the old word in place.
    applyStimulus(2, 4'hF, 32'h30, 32'h0BADC0DE);
    idleCycles(1);
    @(negedge clk);
    reqEn[2] = 1'b1; reqWen[2] = 4'hF; reqAddr[2] = 32'h30; reqWdata[2] = 32'hCAFEF00D;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rst_busy_ok", 2, 32'(dataOk[2]), 32'd0);
    for (int k = 0; k < 3; k++) begin
      lastRdata[k] = 32'd0;
      checkOutput("rst_rdata", k, rdataV[k], 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    reqEn[2] = 1'b0;
    idleCycles(2);
    applyStimulus(2, 4'h0, 32'h30, 32'h0);
    checkOutput("dropped_store", 2, rdataV[2], 32'h0BADC0DE);
    rst = 1'b1;
    #1;
    checkOutput("rst_done_ok", 2, 32'(dataOk[2]), 32'd0);
    checkOutput("rst_done_rdata", 2, rdataV[2], 32'd0);
    for (int k = 0; k < 3; k++) lastRdata[k] = 32'd0;
    @(negedge clk);
    rst = 1'b0;
    reqEn[2] = 1'b0;
    idleCycles(2);

    applyStimulus(1, 4'hF, 32'h40, 32'h12345678);
    applyStimulus(1, 4'hF, 32'h42, 32'hFFFFFFFF);
    applyStimulus(1, 4'h0, 32'h40, 32'h0);
    idleCycles(1);

    for (int i = 0; i < 16; i++) applyStimulus(1, 4'hF, 32'h400 + 32'(4 * i), $urandom());
    for (int i = 0; i < 40; i++) begin
      r    = $urandom();
      word = 10'h100 + 10'($urandom_range(0, 15));
      low  = 2'($urandom_range(0, 3));
      wen  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      applyStimulus(1, wen, {r[31:12], word, low}, $urandom());
      if ($urandom_range(0, 2) == 0) idleCycles(1);
    end
    idleCycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
